// File: rtl/core_pkg.sv
// ============================================================================
// core_pkg
// ----------------------------------------------------------------------------
// Purpose : Shared definitions for the instruction fetch front end.
//           Holds the fetch FSM state type, the default datapath width, the
//           canonical NOP encoding and a small alignment helper.
//
// Contents:
//   XLEN_DEFAULT  - default instruction / address width
//   NOP_INSTR     - RISC-V style "addi x0, x0, 0" encoding
//   fetch_state_t - IDLE / RUN / FLUSH / HALT
//   word_aligned  - true when the low two address bits are zero
// ============================================================================
package core_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // IDLE : single settling cycle after reset, no requests issued
    // RUN  : normal prefetching
    // FLUSH: waiting for responses to requests issued before a redirect
    // HALT : stopped after a misaligned redirect target
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    // Instruction fetch addresses must be 4-byte aligned.
    function automatic logic word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage : core_pkg

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo
// ----------------------------------------------------------------------------
// Purpose : Synchronous first-word-fall-through FIFO used as the fetch
//           prefetch buffer. Each entry holds {pc, instruction}.
//
// Ports:
//   clk        in   clock, all updates on the rising edge
//   rst        in   synchronous active-high reset, empties the FIFO
//   clear      in   synchronous flush, empties the FIFO (redirects)
//   push       in   write push_data at the tail
//   push_data  in   WIDTH-bit entry to write
//   pop        in   drop the head entry
//   head_data  out  current head entry (valid when empty == 0)
//   count      out  number of stored entries, 0..DEPTH
//   empty      out  count == 0
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A push into a full FIFO is still legal when the head leaves in the
    // same cycle. Clear wins over any push or pop in the same cycle.
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; head_data is only meaningful while not empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr];

endmodule : fetch_fifo

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit
// ----------------------------------------------------------------------------
// Purpose : Instruction fetch front end. Issues sequential fetch requests to
//           instruction memory, buffers in-order responses in a prefetch FIFO
//           and hands {pc, instruction} pairs to decode. Redirects flush the
//           buffer and discard responses to requests issued before them.
//
// Parameters:
//   XLEN      instruction / address width
//   DEPTH     prefetch entries and maximum outstanding requests (power of 2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk             in   clock
//   nrst            in   synchronous reset, active high
//   redirect_valid  in   taken branch / jump, load redirect_pc
//   redirect_pc     in   redirect target
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   memory accepts request
//   imem_req_addr   out  fetch address
//   imem_rsp_valid  in   instruction returned (in order, one per request)
//   imem_rsp_data   in   returned instruction
//   if_valid        out  instruction available to decode
//   if_ready        in   decode consumes instruction
//   if_instr        out  head instruction (0 when empty)
//   if_pc           out  PC of head instruction (0 when empty)
//   misalign_err    out  sticky: last redirect target was misaligned
//   fifo_count      out  buffered entries
// ============================================================================
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [XLEN-1:0]            imem_rsp_data,
    output logic                       if_valid,
    input  logic                       if_ready,
    output logic [XLEN-1:0]            if_instr,
    output logic [XLEN-1:0]            if_pc,
    output logic                       misalign_err,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_t      state;
    fetch_state_t      state_next;

    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   rsp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     outstanding_next;
    logic [CW-1:0]     discard_cnt;
    logic [CW-1:0]     discard_next;
    logic [CW:0]       credit_used;

    logic              req_fire;
    logic              if_fire;
    logic              rsp_any;
    logic              rsp_live;
    logic              push;
    logic              target_aligned;
    logic              fifo_empty;
    logic [2*XLEN-1:0] fifo_head;

    assign req_fire       = imem_req_valid && imem_req_ready;
    assign if_fire        = if_valid && if_ready;
    assign target_aligned = word_aligned(redirect_pc[1:0]);

    // A response only counts when a request is actually outstanding; this
    // drops responses to requests abandoned by a reset.
    assign rsp_any  = imem_rsp_valid && (outstanding != '0);
    assign rsp_live = rsp_any && (discard_cnt == '0);

    // Responses in a redirect cycle belong to the old stream and are dropped.
    assign push = rsp_live && !redirect_valid;

    // Credit covers both buffered entries and requests still in flight so
    // every accepted request is guaranteed a free buffer slot.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};

    // ------------------------------------------------------------------
    // Outstanding request count: +1 per accepted request, -1 per
    // response (live or discarded).
    // ------------------------------------------------------------------
    always_comb begin
        outstanding_next = outstanding;
        if (req_fire && !rsp_any) begin
            outstanding_next = outstanding + 1'b1;
        end else if (!req_fire && rsp_any) begin
            outstanding_next = outstanding - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Discard count. On a redirect everything still in flight after this
    // edge is stale. In FLUSH/HALT no requests are issued, so outstanding
    // already equals discard_cnt there and the same formula simply keeps
    // the running count.
    // ------------------------------------------------------------------
    always_comb begin
        discard_next = discard_cnt;
        if (redirect_valid) begin
            discard_next = outstanding_next;
        end else if (rsp_any && (discard_cnt != '0)) begin
            discard_next = discard_cnt - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM state register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (nrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic. A redirect overrides every other transition.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            if (!target_aligned) begin
                state_next = HALT;
            end else if (discard_next != '0) begin
                state_next = FLUSH;
            end else begin
                state_next = RUN;
            end
        end else begin
            unique case (state)
                IDLE:    state_next = RUN;
                FLUSH:   state_next = (discard_next == '0) ? RUN : FLUSH;
                RUN:     state_next = RUN;
                HALT:    state_next = HALT;
                default: state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM outputs: requests only in RUN and only while a slot is free.
    // ------------------------------------------------------------------
    always_comb begin
        imem_req_valid = 1'b0;
        if ((state == RUN) && (credit_used < (CW+1)'(DEPTH))) begin
            imem_req_valid = 1'b1;
        end
    end

    assign imem_req_addr = fetch_pc;

    // ------------------------------------------------------------------
    // Fetch and response PCs. rsp_pc tracks the PC of the next live
    // response; it restarts at the redirect target together with fetch_pc.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (nrst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                rsp_pc   <= redirect_pc;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (push) begin
                    rsp_pc <= rsp_pc + PC_STEP;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Request bookkeeping and the sticky misalignment flag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (nrst) begin
            outstanding  <= '0;
            discard_cnt  <= '0;
            misalign_err <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            discard_cnt <= discard_next;
            if (redirect_valid) begin
                misalign_err <= !target_aligned;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefetch buffer. Upper half of each entry is the PC.
    // ------------------------------------------------------------------
    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (nrst),
        .clear     (redirect_valid),
        .push      (push),
        .push_data ({rsp_pc, imem_rsp_data}),
        .pop       (if_fire),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // Head fields are forced to zero while empty so nothing stale leaks out.
    assign if_valid = !fifo_empty;
    assign if_pc    = if_valid ? fifo_head[2*XLEN-1:XLEN] : '0;
    assign if_instr = if_valid ? fifo_head[XLEN-1:0]      : '0;

endmodule : instr_fetch_unit

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, instruction and address width.
REQ-002 Parameter DEPTH, default 4, prefetch buffer entries and maximum outstanding requests; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 nrst  in  1  reset, synchronous, active-high (1 = reset asserted).
REQ-006 redirect_valid  in  1  branch/jump taken; load new fetch PC.
REQ-007 redirect_pc  in  XLEN  redirect target.
REQ-008 imem_req_valid  out  1  fetch request valid.
REQ-009 imem_req_ready  in  1  memory accepts request.
REQ-010 imem_req_addr  out  XLEN  fetch address.
REQ-011 imem_rsp_valid  in  1  instruction word returned; in order, one per accepted request, at least 1 cycle after acceptance.
REQ-012 imem_rsp_data  in  XLEN  returned instruction.
REQ-013 if_valid  out  1  instruction available to decode.
REQ-014 if_ready  in  1  decode consumes instruction.
REQ-015 if_instr  out  XLEN  head instruction.
REQ-016 if_pc  out  XLEN  PC of head instruction.
REQ-017 misalign_err  out  1  sticky: last redirect target had bits [1:0] != 0.
REQ-018 fifo_count  out  clog2(DEPTH+1)  buffered entries.

Function
REQ-019 FSM states IDLE, RUN, FLUSH, HALT; transfer = valid AND ready on the same cycle.
REQ-020 IDLE lasts exactly one cycle after reset release, then RUN; no request is issued in IDLE.
REQ-021 imem_req_valid = 1 only in RUN when fifo_count + outstanding < DEPTH (credit reserved, so the buffer never overflows).
REQ-022 imem_req_addr = fetch_pc; held stable while imem_req_valid and not imem_req_ready.
REQ-023 fetch_pc increments by 4 on each request transfer, wrapping modulo 2^XLEN.
REQ-024 Non-stale responses are pushed as {pc, instr} with no backpressure; if_valid asserts the cycle after the push (1-cycle latency).
REQ-025 if_valid = fifo_count != 0; pop on if_valid AND if_ready; simultaneous push and pop leaves fifo_count unchanged.
REQ-026 Redirect has priority over every other event and takes effect at the next edge: an if handshake in the redirect cycle completes; the buffer is then cleared and fetch_pc = redirect_pc.
REQ-027 On redirect, discard_cnt = outstanding requests (including any accepted in the redirect cycle) minus any response arriving in the redirect cycle; responses are dropped while discard_cnt > 0.
REQ-028 Next state after an aligned redirect: FLUSH if discard_cnt > 0, else RUN; FLUSH goes to RUN in the cycle discard_cnt reaches 0; no requests are issued in FLUSH.
REQ-029 A redirect during FLUSH or HALT updates fetch_pc and keeps the current discard_cnt.
REQ-030 A redirect with redirect_pc[1:0] != 0 sets misalign_err, clears the buffer, enters HALT and issues no requests; stale responses are still discarded.
REQ-031 An aligned redirect clears misalign_err and exits HALT per REQ-028.

Reset
REQ-032 Reset gives: state IDLE, fetch_pc = RESET_PC, buffer empty, outstanding = 0, discard_cnt = 0, all outputs 0, imem_req_addr = RESET_PC.
REQ-033 Reset mid-operation abandons in-flight requests; responses arriving after reset are not buffered until requests issued after reset are outstanding.

Structure
REQ-034 Shared package core_pkg holds the state enum fetch_state_t, the XLEN default and the NOP constant 32'h0000_0013.
REQ-035 Buffer is a sub-module fetch_fifo: synchronous FIFO of width 2*XLEN and depth DEPTH, with push, pop, clear and count ports.

Verification
REQ-036 Reset, then imem_req_ready = 1 with 1-cycle response latency and if_ready = 1 -> addresses 0x0, 0x4, 0x8... in order; first if_valid 3 cycles after reset release, with if_pc = 0x0.
REQ-037 if_ready = 0, DEPTH = 4 -> exactly 4 requests accepted, fifo_count = 4, imem_req_valid = 0 until a pop.
REQ-038 Redirect to 0x100 with 2 requests outstanding -> next 2 responses dropped, FLUSH for 2 cycles, next request addr 0x100, first if_pc = 0x100.
REQ-039 Redirect to 0x102 -> misalign_err = 1, no requests; then redirect to 0x200 -> misalign_err = 0, fetch resumes at 0x200.
REQ-040 fetch_pc = 0xFFFF_FFFC -> next request addr 0x0000_0000; also, nrst asserted with a full buffer -> all outputs 0 on the next cycle.
